sim_reset_watchdog: RTL
=======================

# sim_reset_watchdog

Parametrised reset-sequencing and run-supervision block for the simulation top of the RISC-V CPU. It replaces the fixed reset pulse and the fixed `$finish` delay with hardware that does three things: releases N reset domains in a staggered order, counts run cycles, and ends the run on a program halt, a global timeout or a commit stall. It sits between the testbench clock/reset source and `riscv_top`. The testbench watches `done` and `done_code` to end the simulation and report why it ended.

## Interface
- `N_RST`, default 2: number of reset domains; must be ≥ 1.
- `RST_CYCLES`, default 25: edges after `rst` deassertion before `rst_out[0]` releases; must be ≥ 1.
- `STAGGER`, default 4: extra edges between consecutive domain releases.
- `CNT_W`, default 32: width of the cycle and idle counters.
- `TIMEOUT`, default 1500: run-cycle limit; 0 disables it.
- `STALL_LIMIT`, default 256: consecutive heartbeat-free run cycles allowed; 0 disables it.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `heartbeat` in 1: commit pulse from the core.
- `halt_req` in 1: program-end request (the core's halt I/O write).
- `rst_out` out N_RST: per-domain active-high resets.
- `running` out 1: high while in RUN.
- `done` out 1: sticky end-of-run flag.
- `done_code` out 2: end reason. 0 = none, 1 = halt, 2 = timeout, 3 = stall.
- `cycle_cnt` out CNT_W: run-cycle count.

## Operation
- States: RESET, HOLD, RUN, DONE.
- RESET (entered whenever `rst` is high, asynchronously):
  - `rst_out` = all ones; `running` = 0; `done` = 0; `done_code` = 0; `cycle_cnt` = 0.
  - Hold counter and idle counter = 0.
- HOLD (first edge with `rst` low onward):
  - Hold counter increments by 1 every edge.
  - `rst_out[i]` clears on the edge where the hold counter becomes RST_CYCLES + i*STAGGER.
  - On the edge that clears `rst_out[N_RST-1]`, the state moves to RUN, `running` goes to 1 and `cycle_cnt` = 0.
- RUN, per edge:
  - `cycle_cnt` increments by 1, including on the exit edge, and saturates at all ones.
  - `heartbeat` high clears the idle counter; otherwise the idle counter increments.
  - Exit to DONE, checked in priority order on the same edge:
    1. `halt_req` high → `done_code` = 1.
    2. `cycle_cnt` becoming TIMEOUT (TIMEOUT ≠ 0) → `done_code` = 2.
    3. Idle counter becoming STALL_LIMIT (STALL_LIMIT ≠ 0) → `done_code` = 3.
  - On exit: `done` = 1, `running` = 0.
- DONE:
  - All outputs frozen; `rst_out` stays 0.
  - `heartbeat` and `halt_req` are ignored.
  - The only way out is `rst`.
- `heartbeat` and `halt_req` are also ignored in RESET and HOLD.
- Arithmetic:
  - Counters are unsigned, CNT_W bits wide.
  - Release thresholds are computed at elaboration; the max threshold must fit in CNT_W.

## Timing
- `rst` assertion takes effect immediately, without waiting for an edge, and at any point, including mid-RUN and in DONE.
- Deassertion is sampled synchronously: the first `clk` edge with `rst` low is hold count 1.
- Default release points after `rst` falls:
  - `rst_out[0]` low at edge 25.
  - `rst_out[1]` low and `running` high at edge 29.
- Inputs are sampled at the edge; the response is visible after that same edge, with zero added latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, `rst` high 25 cycles then low → `rst_out` = 2'b10 at edge 25, 2'b00 at edge 29, `running` = 1 and `cycle_cnt` = 0 at edge 29.
- `halt_req` pulsed while `cycle_cnt` = 99 → `done` = 1, `done_code` = 1, `cycle_cnt` frozen at 100, `running` = 0.
- `heartbeat` every 10 cycles, no halt, TIMEOUT = 1500 → `done_code` = 2 with `cycle_cnt` = 1500.
- Last `heartbeat` while `cycle_cnt` = 50, STALL_LIMIT = 256 → `done_code` = 3 with `cycle_cnt` = 307.
- `halt_req` high on the edge where `cycle_cnt` becomes 1500 → `done_code` = 1, not 2.
- `rst` raised mid-RUN between edges at `cycle_cnt` = 40 → `rst_out` = all ones and `cycle_cnt` = 0 immediately; after `rst` falls, the release sequence repeats exactly as in the first scenario. Repeat with `rst` raised in DONE → `done` clears.

Source files
------------

// File: rtl/sim_reset_watchdog_if.sv
// -----------------------------------------------------------------------------
// sim_reset_watchdog_if
// Groups the supervision signals between the reset watchdog and the
// supervised CPU/testbench side.
//
//   heartbeat  : commit pulse from the core
//   halt_req   : program-end request from the core
//   rst_out    : per-domain active-high resets
//   running    : high while the core is being supervised in RUN
//   done       : sticky end-of-run flag
//   done_code  : end reason (0 none, 1 halt, 2 timeout, 3 stall)
//   cycle_cnt  : run-cycle count
//
// The master modport is the watchdog itself.
// The slave modport is the supervised side, which drives heartbeat/halt_req
// and observes everything else.
// -----------------------------------------------------------------------------
interface sim_reset_watchdog_if #(
   parameter int N_RST = 2,
   parameter int CNT_W = 32
);
   logic             heartbeat;
   logic             halt_req;
   logic [N_RST-1:0] rst_out;
   logic             running;
   logic             done;
   logic [1:0]       done_code;
   logic [CNT_W-1:0] cycle_cnt;

   modport master (
      input  heartbeat,
      input  halt_req,
      output rst_out,
      output running,
      output done,
      output done_code,
      output cycle_cnt
   );

   modport slave (
      output heartbeat,
      output halt_req,
      input  rst_out,
      input  running,
      input  done,
      input  done_code,
      input  cycle_cnt
   );
endinterface

// File: rtl/sim_reset_watchdog.sv
// -----------------------------------------------------------------------------
// sim_reset_watchdog
// Reset sequencing and run supervision for the simulation top.
//
// Reset release:
//   - Releases N_RST reset domains in a staggered order after rst falls.
//
// Run supervision:
//   - Counts run cycles.
//   - Ends the run on a halt request, a global timeout or a commit stall.
//
// Ports:
//   clk  : single rising-edge clock
//   rst  : asynchronous active-high reset
//   wd   : sim_reset_watchdog_if.master
//          (heartbeat/halt_req in; rst_out, running, done, done_code and
//          cycle_cnt out, all registered)
//
// Parameter constraints:
//   - N_RST >= 1 and RST_CYCLES >= 1.
//   - The last release threshold, RST_CYCLES + (N_RST-1)*STAGGER, must fit
//     in CNT_W bits.
//   - TIMEOUT = 0 disables the timeout check.
//   - STALL_LIMIT = 0 disables the stall check.
// -----------------------------------------------------------------------------
module sim_reset_watchdog #(
   parameter int N_RST       = 2,
   parameter int RST_CYCLES  = 25,
   parameter int STAGGER     = 4,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 1500,
   parameter int STALL_LIMIT = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   sim_reset_watchdog_if.master wd
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_THR  = CNT_W'(RST_CYCLES + (N_RST - 1) * STAGGER);
   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] STALL_V   = CNT_W'(STALL_LIMIT);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_HOLD,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] idle_cnt;
   logic [CNT_W-1:0] cycle_q;
   logic [N_RST-1:0] rst_out_q;
   logic             running_q;
   logic             done_q;
   logic [1:0]       code_q;

   logic [CNT_W-1:0] hold_next;
   logic [CNT_W-1:0] cycle_next;
   logic [CNT_W-1:0] idle_next;

   // Next-value arithmetic shared by the state machine.
   // The cycle and idle counters saturate at all ones, so a disabled timeout
   // or stall check can never wrap them back through zero.
   // The hold counter needs no saturation: it stops at the last release
   // threshold.
   always_comb begin
      hold_next  = hold_cnt + ONE;
      cycle_next = (&cycle_q) ? cycle_q : cycle_q + ONE;
      idle_next  = '0;
      if (!wd.heartbeat) begin
         idle_next = (&idle_cnt) ? idle_cnt : idle_cnt + ONE;
      end
   end

   // Main sequencer: RESET -> HOLD -> RUN -> DONE.
   //
   // RESET and HOLD share one branch because the first edge with rst low
   // already counts as hold count 1.
   //
   // Each domain drops its reset on the edge where the hold counter lands
   // exactly on its threshold.
   //
   // In RUN, exit reasons are tested in priority order (halt, then timeout,
   // then stall). The counters still advance on the exit edge, so the frozen
   // values include that last cycle.
   //
   // DONE holds every register until rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_RESET;
         hold_cnt  <= '0;
         idle_cnt  <= '0;
         cycle_q   <= '0;
         rst_out_q <= '1;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         code_q    <= 2'd0;
      end else begin
         case (state)
            ST_RESET, ST_HOLD: begin
               state    <= ST_HOLD;
               hold_cnt <= hold_next;
               for (int i = 0; i < N_RST; i++) begin
                  if (hold_next == CNT_W'(RST_CYCLES + i * STAGGER)) begin
                     rst_out_q[i] <= 1'b0;
                  end
               end
               if (hold_next == LAST_THR) begin
                  state     <= ST_RUN;
                  running_q <= 1'b1;
                  cycle_q   <= '0;
                  idle_cnt  <= '0;
               end
            end
            ST_RUN: begin
               cycle_q  <= cycle_next;
               idle_cnt <= idle_next;
               if (wd.halt_req) begin
                  state     <= ST_DONE;
                  done_q    <= 1'b1;
                  running_q <= 1'b0;
                  code_q    <= 2'd1;
               end else if ((TIMEOUT != 0) && (cycle_next == TIMEOUT_V)) begin
                  state     <= ST_DONE;
                  done_q    <= 1'b1;
                  running_q <= 1'b0;
                  code_q    <= 2'd2;
               end else if ((STALL_LIMIT != 0) && (idle_next == STALL_V)) begin
                  state     <= ST_DONE;
                  done_q    <= 1'b1;
                  running_q <= 1'b0;
                  code_q    <= 2'd3;
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state <= ST_RESET;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   // There are no combinational paths from heartbeat/halt_req to the
   // outputs.
   assign wd.rst_out   = rst_out_q;
   assign wd.running   = running_q;
   assign wd.done      = done_q;
   assign wd.done_code = code_q;
   assign wd.cycle_cnt = cycle_q;

endmodule
